// File: rtl/flash_player_pkg.sv
// Shared types and constants for the flash sample player: FSM states, default
// sample region bounds and the byte lanes that carry the two samples of a word.
package flash_player_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadReq,
    StReadWait,
    StEmitA,
    StWaitTick,
    StEmitB,
    StNextAddr
  } player_state_e;

  localparam int unsigned DefaultAddrW     = 23;
  localparam logic [22:0] DefaultStartAddr = 23'h000000;
  localparam logic [22:0] DefaultEndAddr   = 23'h07FFFF;

  // Each 32-bit word carries two 8-bit samples in lanes [15:8] and [31:24].
  localparam int unsigned LaneLoLsb = 8;
  localparam int unsigned LaneHiLsb = 24;

  function automatic logic [7:0] sample_lane(input logic [31:0] word, input logic upper);
    return upper ? word[LaneHiLsb +: 8] : word[LaneLoLsb +: 8];
  endfunction

endpackage

// File: rtl/flash_sample_player_if.sv
// Avalon-MM read channel between the sample player (master) and the flash
// controller (slave).
interface flash_sample_player_if
  import flash_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/wrap_addr_counter.sv
// Up/down word-address counter confined to the inclusive range
// [StartAddr, EndAddr], wrapping at either end; load returns it to StartAddr.
module wrap_addr_counter #(
  parameter int unsigned      AddrW     = 23,
  parameter logic [AddrW-1:0] StartAddr = '0,
  parameter logic [AddrW-1:0] EndAddr   = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [AddrW-1:0] addr_o
);

  logic [AddrW-1:0] addr_q, addr_d;

  // Load has priority over stepping; dir_i = 1 counts toward lower addresses.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = StartAddr;
    end else if (en_i) begin
      if (dir_i) begin
        addr_d = (addr_q == StartAddr) ? EndAddr : addr_q - AddrW'(1);
      end else begin
        addr_d = (addr_q == EndAddr) ? StartAddr : addr_q + AddrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= StartAddr;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/flash_sample_player.sv
// Walks the flash sample region word by word, reading each word over Avalon-MM
// and emitting its two 8-bit samples on successive sample ticks.
module flash_sample_player
  import flash_player_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DefaultAddrW,
  parameter logic [ADDR_W-1:0] START_ADDR = DefaultStartAddr,
  parameter logic [ADDR_W-1:0] END_ADDR   = DefaultEndAddr
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_tick,
  input  logic                         pause,
  input  logic                         reverse,
  input  logic                         restart,
  flash_sample_player_if.master        flash_mem,
  output logic [7:0]                   audio_data,
  output logic                         sample_valid
);

  player_state_e     state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic              dir_q, dir_d;
  logic              pending_q, pending_d;
  logic [7:0]        audio_q, audio_d;
  logic              cnt_load, cnt_en;
  logic [ADDR_W-1:0] addr;

  wrap_addr_counter #(
    .AddrW     (ADDR_W),
    .StartAddr (START_ADDR),
    .EndAddr   (END_ADDR)
  ) u_addr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .dir_i   (dir_q),
    .addr_o  (addr)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    dir_d        = dir_q;
    pending_d    = pending_q;
    audio_d      = audio_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    sample_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (restart) begin
          cnt_load = 1'b1;
        end else if (sample_tick && !pause) begin
          state_d = StReadReq;
        end
      end
      // A read in flight is never abandoned; restart is remembered until the data returns.
      StReadReq: begin
        if (restart) pending_d = 1'b1;
        if (!flash_mem.flash_mem_waitrequest) state_d = StReadWait;
      end
      StReadWait: begin
        if (restart) pending_d = 1'b1;
        if (flash_mem.flash_mem_readdatavalid) begin
          if (pending_q || restart) begin
            cnt_load  = 1'b1;
            pending_d = 1'b0;
            state_d   = StIdle;
          end else begin
            word_d  = flash_mem.flash_mem_readdata;
            state_d = StEmitA;
          end
        end
      end
      StEmitA: begin
        if (restart) begin
          cnt_load = 1'b1;
          state_d  = StIdle;
        end else begin
          dir_d        = reverse;
          audio_d      = sample_lane(word_q, reverse);
          sample_valid = 1'b1;
          state_d      = StWaitTick;
        end
      end
      StWaitTick: begin
        if (restart) begin
          cnt_load = 1'b1;
          state_d  = StIdle;
        end else if (sample_tick && !pause) begin
          state_d = StEmitB;
        end
      end
      // Second half follows the direction latched at EMIT_A, not the live input.
      StEmitB: begin
        if (restart) begin
          cnt_load = 1'b1;
          state_d  = StIdle;
        end else begin
          audio_d      = sample_lane(word_q, !dir_q);
          sample_valid = 1'b1;
          state_d      = StNextAddr;
        end
      end
      StNextAddr: begin
        if (restart) begin
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      word_q    <= '0;
      dir_q     <= 1'b0;
      pending_q <= 1'b0;
      audio_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      audio_q   <= audio_d;
    end
  end

  assign flash_mem.flash_mem_read       = (state_q == StReadReq);
  assign flash_mem.flash_mem_address    = addr;
  assign flash_mem.flash_mem_byteenable = 4'hF;
  assign audio_data                     = audio_d;

endmodule

// File: tb/tb_flash_sample_player.sv
// Self-checking bench for flash_sample_player: a transaction-level model of the
// sample stream and address walk, checked every cycle, plus directed literals.
module tb_flash_sample_player;

  localparam logic [22:0] StartA = 23'h000000;
  localparam logic [22:0] EndA   = 23'h07FFFF;

  logic       clk;
  logic       reset_n;
  logic       sample_tick, pause, reverse, restart;
  logic [7:0] audio_data;
  logic       sample_valid;

  flash_sample_player_if #(.ADDR_W(23)) mem_if ();

  flash_sample_player dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .pause        (pause),
    .reverse      (reverse),
    .restart      (restart),
    .flash_mem    (mem_if),
    .audio_data   (audio_data),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flash contents: word 0 is pinned, the rest is a simple hash of the address.
  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'h0) return 32'h12345678;
    return ({9'h0, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Reference model state
  logic [22:0] exp_addr;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_audio;
  logic        read_expected;

  // Flash slave state
  int          stall_left, delay_cfg, rsp_count, slv_delay;
  logic        slv_pending;
  logic [22:0] slv_addr;

  always @(posedge clk) begin
    if (mem_if.flash_mem_readdatavalid) rsp_count++;
    if (mem_if.flash_mem_read && !mem_if.flash_mem_waitrequest) begin
      slv_pending = 1'b1;
      slv_addr    = mem_if.flash_mem_address;
      slv_delay   = delay_cfg;
    end else if (mem_if.flash_mem_read && stall_left > 0) begin
      stall_left--;
    end
    #2;
    mem_if.flash_mem_waitrequest = (stall_left > 0);
    if (slv_pending && slv_delay == 0) begin
      mem_if.flash_mem_readdatavalid = 1'b1;
      mem_if.flash_mem_readdata      = mem_word(slv_addr);
      slv_pending                    = 1'b0;
    end else begin
      mem_if.flash_mem_readdatavalid = 1'b0;
      mem_if.flash_mem_readdata      = $urandom;
      if (slv_pending) slv_delay--;
    end
  end

  // Per-cycle compare against the model
  logic        prev_stalled;
  logic [22:0] prev_addr;
  initial prev_stalled = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      chk("byteenable", {28'h0, mem_if.flash_mem_byteenable}, 32'hF);
      if (mem_if.flash_mem_read) begin
        chk("read_allowed", {31'h0, read_expected}, 32'h1);
        chk("req_addr", {9'h0, mem_if.flash_mem_address}, {9'h0, exp_addr});
        if (prev_stalled) chk("addr_stable", {9'h0, mem_if.flash_mem_address}, {9'h0, prev_addr});
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", {31'h0, sample_valid}, 32'h0);
        end else begin
          exp_audio = exp_q.pop_front();
          chk("sample", {24'h0, audio_data}, {24'h0, exp_audio});
        end
      end else begin
        chk("audio_hold", {24'h0, audio_data}, {24'h0, exp_audio});
      end
      prev_stalled = mem_if.flash_mem_read && mem_if.flash_mem_waitrequest;
      prev_addr    = mem_if.flash_mem_address;
    end else begin
      prev_stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] next_addr(input logic [22:0] a, input logic rev);
    if (rev) return (a == StartA) ? EndA : a - 23'd1;
    return (a == EndA) ? StartA : a + 23'd1;
  endfunction

  // rmode: 0 = play both halves, 1 = restart while the read is in flight,
  // 2 = restart while waiting for the second tick.
  task automatic do_word(input logic rev, input int stall, input int dly, input int pticks,
                         input int rmode, output logic [7:0] s_a, output logic [7:0] s_b,
                         output logic [22:0] req_addr);
    logic [31:0] w;
    logic [7:0]  ea;
    int          lat, rsp0;
    w          = mem_word(exp_addr);
    ea         = rev ? w[31:24] : w[15:8];
    s_a        = 8'h00;
    s_b        = 8'h00;
    reverse    = rev;
    pause      = 1'b0;
    stall_left = stall;
    delay_cfg  = dly;
    rsp0       = rsp_count;
    read_expected = 1'b1;
    if (rmode != 1) exp_q.push_back(ea);
    sample_tick = 1'b1;
    step();
    req_addr = mem_if.flash_mem_address;
    if (rmode == 1) begin
      sample_tick = 1'b0;
      restart     = 1'b1;
      step();
      restart = 1'b0;
      lat = 0;
      while (rsp_count == rsp0 && lat < 100) begin
        step();
        lat++;
      end
      chk("restart_read_done", {31'h0, rsp_count != rsp0}, 32'h1);
      step();
      read_expected = 1'b0;
      exp_addr      = StartA;
      return;
    end
    // Tick stays high while the read is in flight; those ticks must be dropped.
    lat = 1;
    while (!sample_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("latency", lat, 3 + stall + dly);
    s_a           = audio_data;
    sample_tick   = 1'b0;
    step();
    read_expected = 1'b0;
    reverse       = 1'($urandom_range(0, 1));
    pause         = 1'b1;
    for (int i = 0; i < pticks; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
    end
    if (pticks > 0) chk("pause_hold", {24'h0, audio_data}, {24'h0, ea});
    pause = 1'b0;
    if (rmode == 2) begin
      restart = 1'b1;
      step();
      restart  = 1'b0;
      exp_addr = StartA;
      s_b      = audio_data;
      step();
      return;
    end
    exp_q.push_back(rev ? w[15:8] : w[31:24]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("emit_b_valid", {31'h0, sample_valid}, 32'h1);
    s_b = audio_data;
    step();
    step();
    exp_addr = next_addr(exp_addr, rev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0]  a, b;
    logic [22:0] ra;
    int          r;
    reset_n       = 1'b0;
    sample_tick   = 1'b0;
    pause         = 1'b0;
    reverse       = 1'b0;
    restart       = 1'b0;
    stall_left    = 0;
    delay_cfg     = 0;
    rsp_count     = 0;
    slv_pending   = 1'b0;
    slv_delay     = 0;
    slv_addr      = '0;
    exp_addr      = StartA;
    exp_audio     = 8'h00;
    read_expected = 1'b0;
    mem_if.flash_mem_waitrequest   = 1'b0;
    mem_if.flash_mem_readdatavalid = 1'b0;
    mem_if.flash_mem_readdata      = 32'h0;
    #1;
    chk("rst_read", {31'h0, mem_if.flash_mem_read}, 32'h0);
    chk("rst_audio", {24'h0, audio_data}, 32'h0);
    chk("rst_valid", {31'h0, sample_valid}, 32'h0);
    chk("rst_addr", {9'h0, mem_if.flash_mem_address}, 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Forward fetch at address 0
    do_word(1'b0, 0, 0, 0, 0, a, b, ra);
    chk("t1_addr", {9'h0, ra}, 32'h0);
    chk("t1_a", {24'h0, a}, 32'h56);
    chk("t1_b", {24'h0, b}, 32'h12);
    do_word(1'b0, 1, 2, 0, 0, a, b, ra);
    chk("t1_next_addr", {9'h0, ra}, 32'h1);

    // Restart from IDLE, then reverse at START_ADDR
    restart = 1'b1;
    step();
    restart  = 1'b0;
    exp_addr = StartA;
    step();
    do_word(1'b1, 0, 1, 0, 0, a, b, ra);
    chk("t2_addr", {9'h0, ra}, 32'h0);
    chk("t2_a", {24'h0, a}, 32'h12);
    chk("t2_b", {24'h0, b}, 32'h56);

    // Forward at END_ADDR wraps to 0
    do_word(1'b0, 2, 0, 0, 0, a, b, ra);
    chk("t2_next_addr", {9'h0, ra}, 32'h07FFFF);

    // Pause across three ticks in WAIT_TICK
    do_word(1'b0, 0, 0, 3, 0, a, b, ra);
    chk("t3_wrap_addr", {9'h0, ra}, 32'h0);
    chk("t4_a", {24'h0, a}, 32'h56);
    chk("t4_b", {24'h0, b}, 32'h12);

    // Restart while the read is stalled for four cycles
    do_word(1'b0, 4, 1, 0, 1, a, b, ra);
    chk("t5_addr", {9'h0, ra}, 32'h1);
    do_word(1'b0, 0, 0, 0, 0, a, b, ra);
    chk("t5_next_addr", {9'h0, ra}, 32'h0);

    // Randomized playback
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        pause       = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        pause = 1'b0;
      end else if (r == 1) begin
        pause   = 1'b1;
        restart = 1'b1;
        step();
        restart     = 1'b0;
        exp_addr    = StartA;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        pause = 1'b0;
      end
      r = $urandom_range(0, 9);
      do_word(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), (r == 0) ? 1 : ((r == 1) ? 2 : 0), a, b, ra);
    end

    // Reset while waiting for read data
    do_word(1'b0, 0, 0, 0, 0, a, b, ra);
    stall_left    = 0;
    delay_cfg     = 5;
    read_expected = 1'b1;
    sample_tick   = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("t6_read", {31'h0, mem_if.flash_mem_read}, 32'h0);
    chk("t6_audio", {24'h0, audio_data}, 32'h0);
    chk("t6_valid", {31'h0, sample_valid}, 32'h0);
    slv_pending   = 1'b0;
    exp_q.delete();
    exp_audio     = 8'h00;
    exp_addr      = StartA;
    read_expected = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    do_word(1'b0, 1, 1, 0, 0, a, b, ra);
    chk("t6_addr_after_reset", {9'h0, ra}, 32'h0);
    chk("t6_a", {24'h0, a}, 32'h56);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
